// File: rtl/counting_tx_pkg.sv
// Shared symbol and state encodings for the counting-sequence generator and detector.
// State encodings equal the symbol each state drives, so the decode is the identity.
package counting_tx_pkg;

  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_ONE   = 2'b01;
  localparam logic [1:0] SYM_TWO   = 2'b10;
  localparam logic [1:0] SYM_THREE = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;
  localparam logic [1:0] ST_THREE = 2'b11;

  function automatic logic [1:0] state_sym(input logic [1:0] st);
    logic [1:0] sym;
    sym = SYM_IDLE;
    unique case (st)
      ST_IDLE:  sym = SYM_IDLE;
      ST_ONE:   sym = SYM_ONE;
      ST_TWO:   sym = SYM_TWO;
      ST_THREE: sym = SYM_THREE;
      default:  sym = SYM_IDLE;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/counting_tx_runctr.sv
// Loadable run-length down-counter; last flags count==1.
// Saturates at zero rather than wrapping.
module counting_tx_runctr
  import counting_tx_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/counting_tx.sv
// Burst generator: 01, then r2 x 10, then r3 x 11, then back to 00 with a done pulse.
// Optional ans_exp/mismatch monitor is built when COUNTING_TX_MONITOR_EN is defined.
module counting_tx
  import counting_tx_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_two,
  input  logic [CNT_W-1:0] n_three,
  output logic [1:0]       num,
  output logic             busy,
  output logic             done
`ifdef COUNTING_TX_MONITOR_EN
  ,
  input  logic             ans_obs,
  output logic             ans_exp,
  output logic             mismatch
`endif
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] r2_q, r2_d, r3_q, r3_d;
  logic             done_q, done_d;
  logic             ctr_load, ctr_dec, ctr_last;
  logic [CNT_W-1:0] ctr_val, ctr_count;

  counting_tx_runctr #(
    .CNT_W (CNT_W)
  ) u_runctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .load_val (ctr_val),
    .count    (ctr_count),
    .last     (ctr_last)
  );

  always_comb begin
    state_d  = state_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    done_d   = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    ctr_val  = r2_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ONE;
          // Zero runs clamp to 1 so the detector never sees 01 directly followed by 11.
          r2_d    = (n_two   == '0) ? CNT_W'(1) : n_two;
          r3_d    = (n_three == '0) ? CNT_W'(1) : n_three;
        end
      end
      ST_ONE: begin
        state_d  = ST_TWO;
        ctr_load = 1'b1;
        ctr_val  = r2_q;
      end
      ST_TWO: begin
        if (ctr_last) begin
          state_d  = ST_THREE;
          ctr_load = 1'b1;
          ctr_val  = r3_q;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_THREE: begin
        ctr_dec = 1'b1;
        if (ctr_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r2_q    <= '0;
      r3_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      done_q  <= done_d;
    end
  end

  assign num  = state_sym(state_q);
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

`ifdef COUNTING_TX_MONITOR_EN
  logic ans_exp_q, mismatch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_exp_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      ans_exp_q <= (num == SYM_THREE);
      if (ans_obs != ans_exp_q) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  assign ans_exp  = ans_exp_q;
  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_counting_tx.sv
// Directed bench for counting_tx: expected {num,busy,done} per cycle are queued at stimulus
// time and popped each cycle. Monitor checks are included when COUNTING_TX_MONITOR_EN is set.
module tb_counting_tx;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_two;
  logic [CNT_W-1:0] n_three;
  logic [1:0]       num;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

`ifdef COUNTING_TX_MONITOR_EN
  logic ans_obs, ans_exp, mismatch, det_ans, force_zero;

  // Reference detector: ans follows every 11 symbol by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) det_ans <= 1'b0;
    else        det_ans <= (num == 2'b11);
  end
  assign ans_obs = force_zero ? 1'b0 : det_ans;
`endif

  counting_tx #(
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n_two    (n_two),
    .n_three  (n_three),
    .num      (num),
    .busy     (busy),
    .done     (done)
`ifdef COUNTING_TX_MONITOR_EN
    ,
    .ans_obs  (ans_obs),
    .ans_exp  (ans_exp),
    .mismatch (mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_next(input string tag);
    logic [3:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: got empty scoreboard expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert ({num, busy, done} === e) else begin
      errors++;
      $error("FAIL %s: got num/busy/done %b expected %b", tag, {num, busy, done}, e);
    end
  endtask

  task automatic push_burst(input int n2, input int n3);
    int r2, r3;
    r2 = (n2 == 0) ? 1 : n2;
    r3 = (n3 == 0) ? 1 : n3;
    sb.push_back(4'b0110);
    for (int i = 0; i < r2; i++) sb.push_back(4'b1010);
    for (int i = 0; i < r3; i++) sb.push_back(4'b1110);
    sb.push_back(4'b0001);
  endtask

  task automatic run_burst(input int n2, input int n3, input string tag);
    @(negedge clk);
    n_two   = n2[CNT_W-1:0];
    n_three = n3[CNT_W-1:0];
    start   = 1'b1;
    push_burst(n2, n3);
    @(posedge clk);
    #1;
    start = 1'b0;
    while (sb.size() > 0) begin
      check_next(tag);
      if (sb.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    n_two   = '0;
    n_three = '0;
`ifdef COUNTING_TX_MONITOR_EN
    force_zero = 1'b0;
`endif
    #12;
    check_val("reset_in", {28'd0, num, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_out", {28'd0, num, busy, done}, 32'h0);

    run_burst(2, 3, "burst_2_3");
    run_burst(0, 0, "burst_clamp");

    // Start held high: second burst accepted in the done cycle; mid-burst input changes ignored.
    @(negedge clk);
    n_two   = 4'd1;
    n_three = 4'd1;
    start   = 1'b1;
    push_burst(1, 1);
    push_burst(1, 1);
    sb.push_back(4'b0000);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      check_next("held_start");
      if (i == 1) begin
        n_two   = 4'd9;
        n_three = 4'd9;
      end
      if (i == 2) begin
        n_two   = 4'd1;
        n_three = 4'd1;
      end
      if (i == 4) start = 1'b0;
    end

    // Asynchronous reset during the second 10 cycle.
    @(negedge clk);
    n_two   = 4'd4;
    n_three = 4'd1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("rst_s0", {28'd0, num, busy, done}, 32'b0110);
    @(posedge clk);
    #1;
    check_val("rst_s1", {28'd0, num, busy, done}, 32'b1010);
    @(posedge clk);
    #1;
    check_val("rst_s2", {28'd0, num, busy, done}, 32'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async", {28'd0, num, busy, done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_nodone", {28'd0, num, busy, done}, 32'h0);
    end
    run_burst(2, 1, "post_rst");

    run_burst(15, 15, "burst_max");
    for (int i = 0; i < 3; i++) begin
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "burst_rand");
    end

`ifdef COUNTING_TX_MONITOR_EN
    check_val("mismatch_clear", {31'd0, mismatch}, 32'd0);
    force_zero = 1'b1;
    run_burst(1, 1, "mon_burst");
    @(posedge clk);
    #1;
    check_val("mismatch_set", {31'd0, mismatch}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
